// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that serialises two req/ack clients onto the single
// address bus of a 1Kx8 RAM with a registered read port.
module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              wr_a,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_wr_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_i_data,
    input  logic [DATA_W-1:0] mem_o_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    state_t            state_q, state_d;
    port_t             sel_q, sel_d;
    port_t             last_q, last_d;
    port_t             winner;
    logic              mem_wr_rd_q, mem_wr_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_i_data_q, mem_i_data_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    // last_q resets to B so that A wins the first contention.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q      <= IDLE;
            sel_q        <= PORT_A;
            last_q       <= PORT_B;
            mem_wr_rd_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_i_data_q <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            mem_wr_rd_q  <= mem_wr_rd_d;
            mem_addr_q   <= mem_addr_d;
            mem_i_data_q <= mem_i_data_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        mem_wr_rd_d  = mem_wr_rd_q;
        mem_addr_d   = mem_addr_q;
        mem_i_data_d = mem_i_data_q;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;

        winner = PORT_A;
        if (req_a && req_b) begin
            winner = (last_q == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            winner = PORT_B;
        end

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    sel_d        = winner;
                    last_d       = winner;
                    mem_addr_d   = (winner == PORT_B) ? addr_b : addr_a;
                    mem_i_data_d = (winner == PORT_B) ? wdata_b : wdata_a;
                    mem_wr_rd_d  = (winner == PORT_B) ? wr_b : wr_a;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // The RAM acts on the edge closing this state; drop the write strobe there.
                mem_wr_rd_d = 1'b0;
                state_d     = mem_wr_rd_q ? ACK : CAPTURE;
            end
            CAPTURE: begin
                if (sel_q == PORT_B) begin
                    rdata_b_d = mem_o_data;
                end else begin
                    rdata_a_d = mem_o_data;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack_a      = (state_q == ACK) && (sel_q == PORT_A);
    assign ack_b      = (state_q == ACK) && (sel_q == PORT_B);
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;
    assign mem_wr_rd  = mem_wr_rd_q;
    assign mem_addr   = mem_addr_q;
    assign mem_i_data = mem_i_data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester, round-robin arbiter and access sequencer for the single-address-bus 1K×8 RAM (`memory_one_addr_bus`: write when `wr_rd`=1 at posedge, registered read when `wr_rd`=0). Two independent clients share the RAM's single port through a req/ack handshake. The block serialises their accesses, drives the RAM's address, data and `wr_rd` lines from registers, and returns read data with a one-cycle ack. It sits between client logic, such as a UART buffer or LED pattern player, and the RAM instance.

## Interface
- ADDR_W, 10, RAM address width (1024 words)
- DATA_W, 8, RAM data width
- clk  in  1  system clock; all logic on posedge
- reset_p  in  1  reset, synchronous and active-high
- req_a / req_b  in  1  access request, level, held until ack
- wr_a / wr_b  in  1  1 = write, 0 = read; held with req
- addr_a / addr_b  in  ADDR_W  access address; held with req
- wdata_a / wdata_b  in  DATA_W  write data; held with req
- ack_a / ack_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  DATA_W  read data, valid while ack high, then held until next read ack for that port
- mem_wr_rd  out  1  to RAM `wr_rd`
- mem_addr  out  ADDR_W  to RAM `addr`
- mem_i_data  out  DATA_W  to RAM `i_data`
- mem_o_data  in  DATA_W  from RAM `o_data`
- busy  out  1  high in every state except IDLE

## Operation
- **Reset values:**
  - state = IDLE.
  - All outputs are 0.
  - last_grant = B, so A wins the first contention.
- **FSM states:** IDLE, ACCESS, CAPTURE, ACK.
- **IDLE:** samples req_a and req_b each edge.
  - Only one request high: grant that requester.
  - Both high: grant the one that is not last_grant.
  - On grant:
    - Register the winner's addr into mem_addr, its wdata into mem_i_data, and its wr into mem_wr_rd.
    - Record the winner in a `sel` register.
    - Update last_grant.
    - Go to ACCESS.
  - No request: stay in IDLE; mem_wr_rd stays 0.
- **ACCESS:** the RAM performs the operation at the edge that ends this state.
  - Write: go to ACK.
  - Read: go to CAPTURE.
  - mem_wr_rd is cleared to 0 on leaving ACCESS, so a write lasts exactly one cycle.
- **CAPTURE:** the RAM's registered o_data is now valid.
  - Load mem_o_data into rdata_<sel>.
  - Go to ACK.
- **ACK:**
  - ack_<sel> = 1 for exactly this cycle.
  - Requests are not sampled; return to IDLE unconditionally.
- **Requester rule:** deassert req at the edge that ends the ack cycle. A req still high in the following IDLE cycle is a new request.
- **Inputs not granted:** ignored. A non-granted requester keeps waiting.
- **mem_addr and mem_i_data:** hold their last values outside ACCESS. Only mem_wr_rd is qualified.
- **Fairness:** under continuous contention the grants alternate A, B, A, B… Neither requester waits more than one foreign transaction.

## Timing
- Let E0 be the IDLE edge that grants the request.
- **Write:**
  - The RAM write occurs at E0+1.
  - ack is high in the cycle after E0+1.
  - Latency is 2 edges from grant to ack.
- **Read:**
  - The RAM latches data at E0+1.
  - rdata is captured at E0+2.
  - ack is high in the cycle after E0+2, with rdata valid in the same cycle.
  - Latency is 3 edges.
- **Throughput (IDLE slot included):**
  - Back-to-back writes: one per 3 cycles.
  - Back-to-back reads: one per 4 cycles.
- **Simultaneous events:**
  - Both requests rising in the same cycle: arbitration is resolved in that same IDLE edge, with no extra cycle.
  - A request arriving during ACCESS, CAPTURE or ACK waits for IDLE.
- **Reset mid-operation:** reset_p high at any edge takes priority over every transition.
  - state goes to IDLE; ack, rdata and mem_* go to 0 at that edge.
  - If reset lands on the ACCESS-ending edge, the RAM still performs the access already registered. The aborted requester receives no ack and must re-request.
- **Address wrap:** none. Addresses pass through unchanged; addr 1023 and addr 0 are legal.

## Test plan
- **Reset:** hold reset_p for 2 cycles mid-read of A.
  - ack_a never pulses; all outputs are 0.
  - The next request from B is serviced normally.
- **Single write/read:** A writes 8'h5A to 10'h3FF, then A reads 10'h3FF.
  - Write ack arrives 2 edges after grant.
  - Read ack arrives 3 edges after grant, with rdata_a = 8'h5A.
  - mem_wr_rd is high for exactly 1 cycle.
- **Contention from reset:** req_a and req_b rise in the same cycle.
  - A is granted first; B is granted in the next IDLE.
  - Each ack pulses exactly once, and ack_a precedes ack_b.
- **Sustained contention:** both hold continuous writes for 6 transactions (A: addr 0..2, B: addr 100..102).
  - Grants alternate A, B, A, B, A, B.
  - RAM readback matches every write.
- **Cross-port read:** B writes 8'hC3 to 10'h000, then A reads 10'h000.
  - rdata_a = 8'hC3.
  - rdata_b is unchanged.
- **Held req:** A keeps req high for one cycle past its ack.
  - A second transaction is issued.
  - mem_wr_rd is never high outside ACCESS.
